ai_move_engine: RTL and testbench

- Sequential computer-player engine for the N x N tic-tac-toe game. It replaces the fixed centre-press AI.
- On the computer's turn it snapshots the board and scans every line, one line per clock. It then picks a move by priority: win, block, centre, corner, free cell.
- The chosen move is driven as a one-hot button pulse into the same move path used by the player buttons.

---
 rtl/ai_move_engine.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_ai_move_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ai_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : ai_move_engine
// Purpose  : Sequential computer player for an N x N tic-tac-toe board.
//            On the computer's turn the board is snapshotted, every line is
//            scanned (one line per clock), and a move is chosen by priority:
//            win, block, centre, corner, free cell. The move is emitted as a
//            one-hot button press held for HOLD cycles.
// Ports    : clk          - system clock
//            reset        - asynchronous active-high reset
//            game_mode    - 1 = single-player game, computer enabled
//            ai_turn      - level, high while it is the computer's turn
//            ai_cells     - CELLS-bit map of computer marks
//            human_cells  - CELLS-bit map of human marks
//            move_valid   - chosen move valid, held HOLD cycles
//            move_onehot  - one-hot press for the chosen cell
//            no_move      - 1-cycle pulse when the board is full
//            busy         - high from scan start until back in IDLE
// Options  : AI_LFSR_FALLBACK_EN - when defined, the last-resort free-cell
//            pick starts from a pseudo-random index taken from a 16-bit LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module ai_move_engine #(
    parameter int N    = 3,
    parameter int HOLD = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           game_mode,
    input  logic           ai_turn,
    input  logic [N*N-1:0] ai_cells,
    input  logic [N*N-1:0] human_cells,
    output logic           move_valid,
    output logic [N*N-1:0] move_onehot,
    output logic           no_move,
    output logic           busy
);

    localparam int c_CELLS  = N * N;
    localparam int c_LINES  = 2 * N + 2;
    localparam int c_LW     = $clog2(c_LINES);
    localparam int c_IW     = $clog2(c_CELLS);
    localparam int c_CW     = $clog2(c_CELLS + 1);
    localparam int c_HW     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int c_CENTER = c_CELLS / 2;
    localparam bit c_ODD    = (N % 2) == 1;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SCAN     = 3'd1;
    localparam logic [2:0] c_ST_PICK     = 3'd2;
    localparam logic [2:0] c_ST_EMIT     = 3'd3;
    localparam logic [2:0] c_ST_WAIT_REL = 3'd4;

    logic [2:0]         r_state;
    logic [c_CELLS-1:0] r_ai;
    logic [c_CELLS-1:0] r_hu;
    logic [c_LW-1:0]    r_line;
    logic [c_HW-1:0]    r_hold;
    logic               r_win_found;
    logic [c_IW-1:0]    r_win_idx;
    logic               r_block_found;
    logic [c_IW-1:0]    r_block_idx;
    logic               r_valid;
    logic [c_CELLS-1:0] r_move_oh;
    logic               r_no_move;
    logic               r_busy;

    // Membership mask of one line. Order: rows, columns, main diagonal,
    // anti-diagonal.
    function automatic logic [c_CELLS-1:0] line_mask(input logic [c_LW-1:0] l);
        logic [c_CELLS-1:0] m;
        int li;
        m  = '0;
        li = int'(l);
        for (int c = 0; c < c_CELLS; c++) begin
            m[c] = ((li < N) && ((c / N) == li)) ||
                   ((li >= N) && (li < 2 * N) && ((c % N) == (li - N))) ||
                   ((li == 2 * N) && ((c / N) == (c % N))) ||
                   ((li == 2 * N + 1) && (((c / N) + (c % N)) == (N - 1)));
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Per-line evaluation of the snapshot
    // ------------------------------------------------------------------
    logic [c_CELLS-1:0] w_mask;
    logic [c_CW-1:0]    w_ai_cnt;
    logic [c_CW-1:0]    w_hu_cnt;
    logic [c_IW-1:0]    w_empty_idx;
    logic               w_empty_ok;
    logic               w_win;
    logic               w_block;

    always_comb begin
        w_mask      = line_mask(r_line);
        w_ai_cnt    = '0;
        w_hu_cnt    = '0;
        w_empty_idx = '0;
        w_empty_ok  = 1'b0;
        for (int c = 0; c < c_CELLS; c++) begin
            if (w_mask[c]) begin
                // A cell carrying both marks counts for both players.
                if (r_ai[c]) w_ai_cnt = w_ai_cnt + c_CW'(1);
                if (r_hu[c]) w_hu_cnt = w_hu_cnt + c_CW'(1);
                if (!r_ai[c] && !r_hu[c] && !w_empty_ok) begin
                    w_empty_idx = c_IW'(c);
                    w_empty_ok  = 1'b1;
                end
            end
        end
        w_win   = (w_ai_cnt == c_CW'(N - 1)) && (w_hu_cnt == '0) && w_empty_ok;
        w_block = (w_hu_cnt == c_CW'(N - 1)) && (w_ai_cnt == '0) && w_empty_ok;
    end

    // ------------------------------------------------------------------
    // Move selection
    // ------------------------------------------------------------------
    logic [c_CELLS-1:0] w_free;
    logic               w_fb_ok;
    logic [c_IW-1:0]    w_fb_idx;
    logic               w_pick_ok;
    logic [c_IW-1:0]    w_pick_idx;
    logic [c_CELLS-1:0] w_pick_oh;

    assign w_free = ~(r_ai | r_hu);

`ifdef AI_LFSR_FALLBACK_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    always_comb begin
        logic [c_IW-1:0] w_k;
        int start;
        w_fb_ok  = 1'b0;
        w_fb_idx = '0;
        w_k      = '0;
        start    = int'(r_lfsr) % c_CELLS;
        for (int c = 0; c < c_CELLS; c++) begin
            w_k = c_IW'((start + c) % c_CELLS);
            if (!w_fb_ok && w_free[w_k]) begin
                w_fb_ok  = 1'b1;
                w_fb_idx = w_k;
            end
        end
    end
`else
    always_comb begin
        w_fb_ok  = 1'b0;
        w_fb_idx = '0;
        for (int c = 0; c < c_CELLS; c++) begin
            if (!w_fb_ok && w_free[c]) begin
                w_fb_ok  = 1'b1;
                w_fb_idx = c_IW'(c);
            end
        end
    end
`endif

    always_comb begin
        w_pick_ok  = 1'b1;
        w_pick_idx = '0;
        if (r_win_found) begin
            w_pick_idx = r_win_idx;
        end else if (r_block_found) begin
            w_pick_idx = r_block_idx;
        end else if (c_ODD && w_free[c_CENTER]) begin
            w_pick_idx = c_IW'(c_CENTER);
        end else if (w_free[0]) begin
            w_pick_idx = '0;
        end else if (w_free[N-1]) begin
            w_pick_idx = c_IW'(N - 1);
        end else if (w_free[c_CELLS-N]) begin
            w_pick_idx = c_IW'(c_CELLS - N);
        end else if (w_free[c_CELLS-1]) begin
            w_pick_idx = c_IW'(c_CELLS - 1);
        end else begin
            // Only the fallback remains; it fails only on a full board.
            w_pick_ok  = w_fb_ok;
            w_pick_idx = w_fb_idx;
        end
        w_pick_oh = c_CELLS'(1) << w_pick_idx;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_ai          <= '0;
            r_hu          <= '0;
            r_line        <= '0;
            r_hold        <= '0;
            r_win_found   <= 1'b0;
            r_win_idx     <= '0;
            r_block_found <= 1'b0;
            r_block_idx   <= '0;
            r_valid       <= 1'b0;
            r_move_oh     <= '0;
            r_no_move     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_no_move <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (game_mode && ai_turn) begin
                        r_ai          <= ai_cells;
                        r_hu          <= human_cells;
                        r_line        <= '0;
                        r_win_found   <= 1'b0;
                        r_block_found <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= c_ST_SCAN;
                    end
                end
                c_ST_SCAN: begin
                    if (!ai_turn || !game_mode) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        // Keep only the first (lowest line index) candidate.
                        if (w_win && !r_win_found) begin
                            r_win_found <= 1'b1;
                            r_win_idx   <= w_empty_idx;
                        end
                        if (w_block && !r_block_found) begin
                            r_block_found <= 1'b1;
                            r_block_idx   <= w_empty_idx;
                        end
                        if (r_line == c_LW'(c_LINES - 1)) begin
                            r_state <= c_ST_PICK;
                        end else begin
                            r_line <= r_line + c_LW'(1);
                        end
                    end
                end
                c_ST_PICK: begin
                    if (!ai_turn || !game_mode) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else if (w_pick_ok) begin
                        r_move_oh <= w_pick_oh;
                        r_valid   <= 1'b1;
                        r_hold    <= c_HW'(HOLD - 1);
                        r_state   <= c_ST_EMIT;
                    end else begin
                        r_no_move <= 1'b1;
                        r_state   <= c_ST_WAIT_REL;
                    end
                end
                c_ST_EMIT: begin
                    // The pulse always runs its full length, even if the
                    // turn is withdrawn meanwhile.
                    if (r_hold == '0) begin
                        r_valid   <= 1'b0;
                        r_move_oh <= '0;
                        r_state   <= c_ST_WAIT_REL;
                    end else begin
                        r_hold <= r_hold - c_HW'(1);
                    end
                end
                c_ST_WAIT_REL: begin
                    if (!ai_turn) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_valid   <= 1'b0;
                    r_move_oh <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign move_valid  = r_valid;
    assign move_onehot = r_move_oh;
    assign no_move     = r_no_move;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ai_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ai_move_engine
// Purpose  : Directed self-checking bench for ai_move_engine (N=3, HOLD=1,
//            AI_LFSR_FALLBACK_EN undefined). Expected moves are hand-derived
//            from the win/block/centre/corner/free-cell priority.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ai_move_engine;

    logic       clk;
    logic       reset;
    logic       game_mode;
    logic       ai_turn;
    logic [8:0] ai_cells;
    logic [8:0] human_cells;
    logic       move_valid;
    logic [8:0] move_onehot;
    logic       no_move;
    logic       busy;

    int total = 0;
    int bad   = 0;

    ai_move_engine #(.N(3), .HOLD(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .game_mode   (game_mode),
        .ai_turn     (ai_turn),
        .ai_cells    (ai_cells),
        .human_cells (human_cells),
        .move_valid  (move_valid),
        .move_onehot (move_onehot),
        .no_move     (no_move),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full computer turn: move_valid must rise after the 10th edge
    // counted from the sampling edge (snapshot edge + 8 lines + pick).
    task automatic do_move(input string tag, input logic [8:0] a, input logic [8:0] h,
                           input logic [8:0] exp_oh, input bit scramble);
        int n;
        bit seen;
        bit busy1;
        bit again;
        n = 0; seen = 0; busy1 = 0; again = 0;
        @(negedge clk);
        ai_cells = a; human_cells = h; ai_turn = 1'b1;
        while (n < 30 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) busy1 = busy;
            if (scramble && n == 3) begin
                ai_cells = 9'h1FF; human_cells = 9'h1FF;
            end
            if (move_valid) seen = 1;
        end
        chk({tag, "_latency"}, n, 10);
        chk({tag, "_busy_start"}, busy1, 1);
        chk({tag, "_onehot"}, move_onehot, exp_oh);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, move_valid, 0);
        chk({tag, "_onehot_clr"}, move_onehot, 0);
        chk({tag, "_busy_wait"}, busy, 1);
        repeat (5) begin
            @(posedge clk); #1;
            if (move_valid) again = 1;
        end
        chk({tag, "_no_repeat"}, again, 0);
        @(negedge clk);
        ai_turn = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int  n;
        bit  vs;
        reset = 1'b1; game_mode = 1'b1; ai_turn = 1'b0;
        ai_cells = '0; human_cells = '0;
        #3;
        chk("reset_valid", move_valid, 0);
        chk("reset_onehot", move_onehot, 0);
        chk("reset_nomove", no_move, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Computer disabled: ai_turn alone must not start a scan.
        game_mode = 1'b0; ai_turn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mode0_busy", busy, 0);
        @(negedge clk);
        ai_turn = 1'b0; game_mode = 1'b1;

        // Empty board -> centre.
        do_move("empty", 9'b000000000, 9'b000000000, 9'b000010000, 0);
        // Win on column 0 (cell 6) beats block on column 1 (cell 7).
        do_move("win", 9'b000001001, 9'b000010010, 9'b001000000, 0);
        // Human threatens row 0 -> block cell 2.
        do_move("block", 9'b000010000, 9'b000000011, 9'b000000100, 0);
        // Centre taken -> first corner.
        do_move("corner0", 9'b000000000, 9'b000010000, 9'b000000001, 0);
        // Human on 0 and 4 threatens the main diagonal -> block cell 8.
        do_move("diag_block", 9'b000000000, 9'b000010001, 9'b100000000, 0);
        // Centre and corner 0 taken, no threats -> corner 2.
        do_move("corner2", 9'b000010000, 9'b000000001, 9'b000000100, 0);
        // All corners and centre taken, no threats -> lowest free cell 1.
        do_move("lowfree", 9'b100000001, 9'b001010100, 9'b000000010, 0);

        // Full board -> no_move pulse, never move_valid.
        n = 0; vs = 0;
        @(negedge clk);
        ai_cells = 9'b010110001; human_cells = 9'b101001110; ai_turn = 1'b1;
        while (n < 30 && !no_move) begin
            @(posedge clk); #1;
            n++;
            if (move_valid) vs = 1;
        end
        chk("full_latency", n, 10);
        chk("full_nomove", no_move, 1);
        @(posedge clk); #1;
        if (move_valid) vs = 1;
        chk("full_nomove_pulse", no_move, 0);
        chk("full_busy_wait", busy, 1);
        repeat (4) begin
            @(posedge clk); #1;
            if (move_valid) vs = 1;
        end
        chk("full_no_valid", vs, 0);
        @(negedge clk);
        ai_turn = 1'b0;
        @(posedge clk); #1;
        chk("full_busy_end", busy, 0);

        // Abort three cycles into SCAN.
        vs = 0;
        @(negedge clk);
        ai_cells = '0; human_cells = '0; ai_turn = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        ai_turn = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        repeat (12) begin
            @(posedge clk); #1;
            if (move_valid || no_move) vs = 1;
        end
        chk("abort_no_move", vs, 0);
        // Fresh scan after abort; board inputs scrambled mid-scan are ignored.
        do_move("restart", 9'b000010000, 9'b000000011, 9'b000000100, 1);

        // Asynchronous reset in the middle of SCAN.
        @(negedge clk);
        ai_cells = '0; human_cells = '0; ai_turn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("prereset_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_valid", move_valid, 0);
        chk("midreset_onehot", move_onehot, 0);
        @(negedge clk);
        ai_turn = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("postreset_busy", busy, 0);

        // Engine still works after reset.
        do_move("after_reset", 9'b000000000, 9'b000000000, 9'b000010000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
